// File: rtl/strobe_sched_ctrl.sv
// rtl/strobe_sched_ctrl.sv - staggered channel bring-up sequencer with per-channel strobe watchdog
module strobe_sched_ctrl #(
    parameter int NUM_CH = 4,   // number of strobe-generator channels (2..16)
    parameter int CNT_W  = 16   // width of stagger and watchdog counters
) (
    input  logic              clk,         // core clock
    input  logic              rst,         // synchronous, active-high
    input  logic              link_up,     // level: 1 brings up / holds, 0 tears down
    input  logic [NUM_CH-1:0] ch_en_mask,  // channels to bring online, latched at start
    input  logic [CNT_W-1:0]  stagger,     // idle cycles after each enabled channel
    input  logic [CNT_W-1:0]  timeout,     // watchdog limit in cycles, 0 disables
    input  logic [NUM_CH-1:0] ch_strobe,   // user_strobe returned from each channel
    input  logic              err_clr,     // pulse: clear strobe_err
    output logic [NUM_CH-1:0] ch_online,   // online enable per channel
    output logic              all_online,  // 1 while running
    output logic              busy,        // 1 outside idle
    output logic [NUM_CH-1:0] strobe_err   // sticky per-channel watchdog error
);

    localparam int               IDX_W    = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STAGGER,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state, state_d;

    logic [NUM_CH-1:0] mask_q;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  wd_cnt [NUM_CH];

    logic              start;      // IDLE -> STAGGER this edge
    logic              slot;       // channel idx is processed this edge
    logic              last_slot;  // final channel processed, entering RUN
    logic              drop;       // link lost in STAGGER/RUN
    logic [NUM_CH-1:0] err_set;

    always_comb begin
        state_d   = state;
        start     = 1'b0;
        slot      = 1'b0;
        last_slot = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (link_up && (ch_en_mask != '0)) begin
                    start   = 1'b1;
                    state_d = ST_STAGGER;
                end
            end
            ST_STAGGER: begin
                if (!link_up) begin
                    drop    = 1'b1;
                    state_d = ST_DRAIN;
                end else if (timer == '0) begin
                    slot = 1'b1;
                    if (idx == LAST_IDX) begin
                        last_slot = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!link_up) begin
                    drop    = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    assign busy = (state != ST_IDLE);

    // Bring-up sequencer: a masked channel consumes one slot and never loads
    // the timer, so it costs exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            idx        <= '0;
            timer      <= '0;
            ch_online  <= '0;
            all_online <= 1'b0;
        end else begin
            if (start) begin
                mask_q <= ch_en_mask;
                idx    <= '0;
                timer  <= '0;
            end
            if ((state == ST_STAGGER) && !drop) begin
                if (!slot) begin
                    timer <= timer - CNT_W'(1);
                end else begin
                    if (mask_q[idx]) begin
                        ch_online[idx] <= 1'b1;
                        timer          <= stagger;
                    end
                    if (!last_slot) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
            end
            if (last_slot) begin
                all_online <= 1'b1;
            end
            if (drop) begin
                ch_online  <= '0;
                all_online <= 1'b0;
            end
        end
    end

    // Error fires only on the edge the counter steps onto timeout; once
    // saturated it cannot fire again until a strobe restarts the count.
    always_comb begin
        err_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            err_set[i] = (state == ST_RUN) && mask_q[i] && !ch_strobe[i] &&
                         (timeout != '0) && (wd_cnt[i] != timeout) &&
                         ((wd_cnt[i] + CNT_W'(1)) == timeout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wd_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (last_slot) begin
                    wd_cnt[i] <= '0;
                end else if ((state == ST_RUN) && mask_q[i]) begin
                    if (ch_strobe[i]) begin
                        wd_cnt[i] <= '0;
                    end else if (wd_cnt[i] != timeout) begin
                        wd_cnt[i] <= wd_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // A set in the same cycle as err_clr wins for that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_err <= '0;
        end else begin
            strobe_err <= (err_clr ? '0 : strobe_err) | err_set;
        end
    end

endmodule

// File: doc/strobe_sched_ctrl.md
# strobe_sched_ctrl

Bring-up sequencer and watchdog for a bank of `NUM_CH` delayed strobe generators. It drives each channel's `online` input in a staggered order once the link is up, so channels do not start in the same cycle. Once all channels are online, it checks that every enabled channel keeps producing `user_strobe` pulses within a programmable timeout. It sits between link-training control and the per-channel strobe generators. It tears all channels down together when the link drops.

## Interface
Parameters:
- `NUM_CH`, default 4: number of strobe-generator channels (2..16).
- `CNT_W`, default 16: width of the stagger and timeout counters.

Ports:
- `clk`  in  1: core clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `link_up`  in  1: level. 1 starts/holds bring-up; 0 tears down.
- `ch_en_mask`  in  NUM_CH: channels to bring online. Latched on IDLE->STAGGER.
- `stagger`  in  CNT_W: idle cycles inserted after each enabled channel goes online. Enabled channels come online `stagger+1` cycles apart.
- `timeout`  in  CNT_W: watchdog limit in cycles without a strobe; 0 disables the watchdog.
- `ch_strobe`  in  NUM_CH: `user_strobe` outputs returned from the channels.
- `err_clr`  in  1: single-cycle pulse that clears `strobe_err`.
- `ch_online`  out  NUM_CH: `online` enable to each channel; registered.
- `all_online`  out  1: 1 while in RUN; registered.
- `busy`  out  1: 1 in STAGGER, RUN and DRAIN.
- `strobe_err`  out  NUM_CH: sticky per-channel watchdog error.

## Operation
- State machine states: IDLE, STAGGER, RUN, DRAIN.
- Internal registers: `mask_q` (NUM_CH bits), `idx` (clog2(NUM_CH) bits), `timer` (CNT_W bits), and one CNT_W watchdog counter per channel.
- **IDLE**
  - `ch_online`=0, `all_online`=0.
  - If `link_up`=1 and `ch_en_mask`!=0: `mask_q`<=`ch_en_mask`, `idx`<=0, `timer`<=0, go to STAGGER.
  - `link_up`=1 with mask=0: stay in IDLE.
- **STAGGER**, with `timer`!=0: `timer` decrements by 1.
- **STAGGER**, with `timer`==0: process channel `idx`.
  - If `mask_q[idx]`=1: set `ch_online[idx]`, `timer`<=`stagger`.
  - If `mask_q[idx]`=0: leave `timer` at 0; a masked channel costs exactly one cycle.
  - If `idx`==NUM_CH-1, go to RUN in the same edge; otherwise `idx`<=`idx`+1.
  - No stagger wait follows the last channel.
- **RUN**
  - `all_online`=1. `ch_online` holds `mask_q`.
  - Watchdog counters are cleared on entry to RUN.
  - Per channel with `mask_q[i]`=1, each cycle:
    - `ch_strobe[i]`=1: counter<=0.
    - Otherwise, if counter!=`timeout`: counter<=counter+1.
    - `strobe_err[i]` is set on the edge where the counter becomes equal to `timeout`, which requires `timeout`!=0.
    - The counter saturates at `timeout`; a later strobe restarts it, but `strobe_err` stays set.
  - Masked channels never set `strobe_err`.
- **Link drop**: `link_up`=0 in STAGGER or RUN goes to DRAIN at that edge, with `ch_online`<=0 and `all_online`<=0 at that same edge.
- **DRAIN**: lasts exactly 1 cycle, then IDLE; `link_up` is ignored during DRAIN. This guarantees at least two consecutive low cycles on `online` before re-entry.
- **`strobe_err` clearing**: `err_clr`=1 clears all bits. If a watchdog sets a bit in the same cycle, the set wins for that bit. `strobe_err` persists through DRAIN/IDLE until cleared.
- **Mid-operation changes**: `stagger`, `timeout` and `ch_en_mask` changes take effect as follows:
  - `stagger` is sampled at each timer load.
  - `timeout` is used live.
  - `ch_en_mask` only takes effect on the next IDLE->STAGGER.
- **Reset**: all outputs 0, state IDLE, all counters 0. Reset overrides everything in the same edge.

## Timing
- Edge 0 is the edge that samples `link_up`=1 in IDLE.
- With all channels enabled and stagger S, channel i goes online after edge 1+i·(S+1). `all_online` rises at the same edge as the last channel.
- Example: NUM_CH=4, S=2, mask=4'b1111.
  - `ch_online` bits rise after edges 1, 4, 7 and 10.
  - `all_online` rises after edge 10.
- Example: mask=4'b0101, S=2.
  - ch0 on after edge 1.
  - ch1 is skipped at edge 4.
  - ch2 on after edge 5.
  - ch3 is skipped at edge 8, which also enters RUN; `all_online` rises after edge 8.
- Teardown: `ch_online` falls one edge after `link_up` is sampled 0. IDLE is reached one edge later. The earliest re-entry to STAGGER is the following edge.
- Watchdog: with timeout T and no strobe, `strobe_err` sets at the T-th RUN edge after the last strobe, or after RUN entry if no strobe has arrived.

## Test plan
- **Reset**: assert `rst` mid-STAGGER with `ch_online`=4'b0011 -> next cycle all outputs are 0 and state is IDLE; with `link_up` still 1, re-bring-up starts from ch0.
- **Full stagger**: NUM_CH=4, S=2, mask=4'hF, raise `link_up` -> `ch_online` rises after edges 1, 4, 7 and 10; `all_online` rises after edge 10.
- **Masked channels with S=0**: mask=4'b0101, S=0 -> ch0 on after edge 1, ch2 on after edge 3, `all_online` after edge 4; ch1 and ch3 never go online.
- **Link drop mid-STAGGER**: drop `link_up` after edge 5 of the full-stagger case -> `ch_online`=0 and `busy`=1 for one DRAIN cycle, then IDLE; on re-raise, the sequence restarts with fresh timing.
- **Watchdog, normal strobes**: timeout=5; ch0 strobes every 3 cycles -> no error.
- **Watchdog, missing strobe**: timeout=5; ch1 has no strobe -> `strobe_err[1]` sets at the 5th RUN edge.
- **Error clearing**: pulse `err_clr` on the same cycle that ch2 first reaches its timeout -> bit 2 remains set and bit 1 clears.
- **Watchdog disabled**: timeout=0 with no strobes for 1000 cycles -> `strobe_err` stays 0.
